// File: rtl/lcd_cmd_issuer.sv
`default_nettype none
// ============================================================================
// lcd_cmd_issuer : FIFO-buffered command feeder for the LCD image controller.
// Optional macro LCD_ISSUER_STATS_EN adds issued_cnt.        Rev 1.0
// ============================================================================
module lcd_cmd_issuer #(
  parameter int DEPTH       = 8,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              host_cmd,
  input  logic                    host_valid,
  output logic                    host_ready,
  output logic [3:0]              lcd_cmd,
  output logic                    lcd_cmd_valid,
  input  logic                    lcd_busy,
  input  logic                    lcd_done,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    session_done,
  output logic                    err_flag
`ifdef LCD_ISSUER_STATS_EN
  ,
  output logic [7:0]              issued_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
  localparam logic [AW-1:0] ACK_LOAD = AW'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_ISSUE, S_ACK, S_RUN, S_WDONE, S_FIN
  } state_t;

  state_t          state, state_n;
  logic [3:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [AW-1:0]   ack_cnt, ack_n;
  logic            low_seen, low_n;
  logic            is_write;
  logic            timeout_err;
  logic            push_req, push_bad, push_ok, pop;

  assign session_done  = (state == S_FIN);
  assign host_ready    = (count < FULL_C) && !session_done;
  assign push_req      = host_valid && host_ready;
  assign push_bad      = push_req && (host_cmd[3:2] == 2'b11);
  assign push_ok       = push_req && !push_bad;
  assign pop           = (state == S_ISSUE);
  assign lcd_cmd_valid = pop;
  assign fifo_count    = count;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= host_cmd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_INIT;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ack_cnt  <= '0;
      low_seen <= 1'b0;
      is_write <= 1'b0;
      lcd_cmd  <= 4'd0;
      err_flag <= 1'b0;
    end else begin
      state    <= state_n;
      ack_cnt  <= ack_n;
      low_seen <= low_n;
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Head is stable from IDLE into ISSUE, so it can be registered one cycle early.
      if (state == S_IDLE && state_n == S_ISSUE) lcd_cmd <= mem[rd_ptr];
      if (pop) is_write <= (lcd_cmd == 4'd0);
      if (push_bad || timeout_err) err_flag <= 1'b1;
    end
  end

  always_comb begin
    state_n     = state;
    ack_n       = ack_cnt;
    low_n       = low_seen;
    timeout_err = 1'b0;
    case (state)
      S_INIT: begin
        low_n = !lcd_busy;
        if (!lcd_busy && low_seen) state_n = S_IDLE;
      end
      S_IDLE: begin
        if (count != '0 && !lcd_busy) state_n = S_ISSUE;
      end
      S_ISSUE: begin
        ack_n   = ACK_LOAD;
        state_n = S_ACK;
      end
      S_ACK: begin
        if (lcd_busy) begin
          state_n = S_RUN;
        end else begin
          ack_n = ack_cnt - AW'(1);
          if (ack_cnt == AW'(1)) begin
            timeout_err = 1'b1;
            state_n     = S_IDLE;
          end
        end
      end
      S_RUN: begin
        if (is_write)      state_n = S_WDONE;
        else if (!lcd_busy) state_n = S_IDLE;
      end
      S_WDONE: begin
        if (lcd_done) state_n = S_FIN;
      end
      S_FIN:   state_n = S_FIN;
      default: state_n = S_INIT;
    endcase
  end

`ifdef LCD_ISSUER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         issued_cnt <= 8'd0;
    else if (pop && issued_cnt != 8'hFF) issued_cnt <= issued_cnt + 8'd1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_issuer.sv
`default_nettype none
// ============================================================================
// tb_lcd_cmd_issuer : scoreboard bench with a simple LCD controller busy model.
// ============================================================================
module tb_lcd_cmd_issuer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] host_cmd;
  logic       host_valid;
  logic       host_ready;
  logic [3:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic       lcd_busy;
  logic       lcd_done;
  logic [3:0] fifo_count;
  logic       session_done;
  logic       err_flag;
`ifdef LCD_ISSUER_STATS_EN
  logic [7:0] issued_cnt;
`endif

  lcd_cmd_issuer #(.DEPTH(8), .ACK_TIMEOUT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .host_cmd      (host_cmd),
    .host_valid    (host_valid),
    .host_ready    (host_ready),
    .lcd_cmd       (lcd_cmd),
    .lcd_cmd_valid (lcd_cmd_valid),
    .lcd_busy      (lcd_busy),
    .lcd_done      (lcd_done),
    .fifo_count    (fifo_count),
    .session_done  (session_done),
    .err_flag      (err_flag)
`ifdef LCD_ISSUER_STATS_EN
    ,
    .issued_cnt    (issued_cnt)
`endif
  );

  always #5 clk = ~clk;

  int         vec  = 0;
  int         errs = 0;
  logic [3:0] exp_q [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Controller model: busy for 3 cycles after each strobe, done pulse when a write finishes.
  logic force_hi = 1'b1;
  logic force_lo = 1'b0;
  logic mb       = 1'b0;
  logic pend     = 1'b0;
  int   mcnt     = 0;
  int   done_cnt = 0;
  logic sd_before = 1'b1;
  logic sd_after  = 1'b0;
  assign lcd_busy = force_hi | (~force_lo & mb);

  initial lcd_done = 1'b0;
  always @(negedge clk) begin
    if (lcd_done) sd_after = session_done;
    lcd_done = 1'b0;
    if (reset) begin
      mcnt = 0; mb = 1'b0; pend = 1'b0;
    end else if (lcd_cmd_valid) begin
      mcnt = 3; mb = 1'b1; pend = (lcd_cmd == 4'd0);
    end else if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        mb = 1'b0;
        if (pend) begin
          sd_before = session_done;
          lcd_done  = 1'b1;
          pend      = 1'b0;
          done_cnt++;
        end
      end
    end
  end

  // Monitor: every strobe pops the scoreboard; strobes must be single-cycle.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (lcd_cmd_valid) begin
      check("strobe_width", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) check("unexpected_issue", {28'd0, lcd_cmd}, 32'hFFFF);
      else                   check("issue_order", {28'd0, lcd_cmd}, {28'd0, exp_q.pop_front()});
    end
    prev_valid = lcd_cmd_valid;
  end

  task automatic push(input logic [3:0] c, output logic acc);
    host_cmd   = c;
    host_valid = 1'b1;
    acc        = host_ready;
    if (acc && c < 4'd12) exp_q.push_back(c);
    @(negedge clk);
    host_valid = 1'b0;
  endtask

  task automatic wait_strobe(input int budget, input string nm);
    int n = 0;
    while (!lcd_cmd_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!lcd_cmd_valid) check(nm, 32'd0, 32'd1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_count != 4'd0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 32'd0);
    repeat (8) @(negedge clk);
  endtask

  logic acc;
  logic seen;
  logic v1, v2;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; host_valid = 1'b0; host_cmd = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_fifo_count", fifo_count, 32'd0);
    check("rst_session",    session_done, 32'd0);
    check("rst_err",        err_flag, 32'd0);
    check("rst_lcd_cmd",    lcd_cmd, 32'd0);
    check("rst_valid",      lcd_cmd_valid, 32'd0);
    check("rst_ready",      host_ready, 32'd1);
`ifdef LCD_ISSUER_STATS_EN
    check("rst_issued_cnt", issued_cnt, 32'd0);
`endif

    // INIT holds while the controller loads its ROM.
    push(4'd7, acc);
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (lcd_cmd_valid) seen = 1'b1;
    end
    check("init_hold", seen, 32'd0);
    force_hi = 1'b0;
    @(negedge clk); v1 = lcd_cmd_valid;
    @(negedge clk); v2 = lcd_cmd_valid;
    check("init_two_low", {31'd0, v1 | v2}, 32'd0);
    wait_strobe(2, "init_issue_timeout");
    drain(50);

    // Full FIFO with the controller held busy.
    force_hi = 1'b1;
    for (int i = 1; i <= 8; i++) push(4'(i), acc);
    check("full_count", fifo_count, 32'd8);
    check("full_ready", host_ready, 32'd0);
    push(4'd9, acc);
    check("ninth_taken", acc, 32'd0);
    check("ninth_count", fifo_count, 32'd8);
    force_hi = 1'b0;
    wait_strobe(6, "full_issue_timeout");
    @(negedge clk);
    check("ready_after_pop", host_ready, 32'd1);
    drain(200);

    // Illegal code is accepted and dropped.
    check("err_pre", err_flag, 32'd0);
    push(4'd13, acc);
    check("illegal_accepted", acc, 32'd1);
    check("illegal_err", err_flag, 32'd1);
    check("illegal_count", fifo_count, 32'd0);
    push(4'd2, acc);
    check("after_illegal_count", fifo_count, 32'd1);
    drain(50);

    // Ack timeout: controller never raises busy.
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("err_cleared", err_flag, 32'd0);
    force_lo = 1'b1;
    push(4'd3, acc);
    push(4'd6, acc);
    wait_strobe(3, "timeout_issue_timeout");
    repeat (4) @(negedge clk);
    check("err_before_timeout", err_flag, 32'd0);
    @(negedge clk);
    check("ack_timeout_err", err_flag, 32'd1);
    wait_strobe(3, "after_timeout_issue");
    force_lo = 1'b0;
    drain(50);

    // Reset in RUN with 3 entries queued.
    push(4'd9, acc);
    push(4'd10, acc);
    push(4'd11, acc);
    push(4'd9, acc);
    check("pre_reset_count", fifo_count, 32'd3);
    check("pre_reset_cmd", lcd_cmd, 32'd9);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check("midrst_count", fifo_count, 32'd0);
    check("midrst_valid", lcd_cmd_valid, 32'd0);
    check("midrst_cmd",   lcd_cmd, 32'd0);
    check("midrst_err",   err_flag, 32'd0);
`ifdef LCD_ISSUER_STATS_EN
    check("midrst_issued_cnt", issued_cnt, 32'd0);
`endif
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Full session ending in the write command.
    push(4'd1, acc);
    push(4'd4, acc);
    push(4'd5, acc);
    push(4'd0, acc);
    begin
      int n = 0;
      while (done_cnt == 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    check("done_pulse_seen", done_cnt, 32'd1);
    repeat (2) @(negedge clk);
    check("session_before_done", sd_before, 32'd0);
    check("session_after_done",  sd_after, 32'd1);
    check("session_sticky", session_done, 32'd1);
    check("fin_ready", host_ready, 32'd0);
    push(4'd2, acc);
    check("fin_push_taken", acc, 32'd0);
    repeat (10) @(negedge clk);
    check("all_issued", exp_q.size(), 32'd0);
`ifdef LCD_ISSUER_STATS_EN
    check("issued_cnt", issued_cnt, 32'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
`default_nettype wire
